serial_ha_adder: RTL and testbench



---
 rtl/serial_ha_adder_pkg.sv | 19 +
 rtl/serial_ha_adder_ha_cell.sv | 13 +
 rtl/serial_ha_adder.sv | 92 +++++++++
 tb/tb_serial_ha_adder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_ha_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding, default width
// and the bit-counter sizing helper.
package serial_ha_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice;
    // clamp to 1 so a zero-width vector can never be produced.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_ha_adder_ha_cell.sv
// One-bit combinational half adder; two of these plus a carry flop make the
// serial full adder.
module ha_cell (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/serial_ha_adder.sv
// Bit-serial unsigned adder, LSB first, one bit per enabled clock, with a
// start/busy/done handshake and back-to-back operation from DONE.
module serial_ha_adder
    import serial_ha_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned    CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_done;

    logic w_ha1_s, w_ha1_c;
    logic w_sum_bit, w_ha2_c;
    logic w_carry_next;
    logic w_accept;

    ha_cell u_ha1 (.x(r_sh_a[0]), .y(r_sh_b[0]), .s(w_ha1_s),   .c(w_ha1_c));
    ha_cell u_ha2 (.x(w_ha1_s),   .y(r_carry),   .s(w_sum_bit), .c(w_ha2_c));

    assign w_carry_next = w_ha1_c | w_ha2_c;
    assign w_accept     = start && ((r_state == IDLE) || (r_state == DONE));

    // NOTE: every flop below uses <= so all of them see pre-edge values of each other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sh_a  <= '0;
            r_sh_b  <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_done  <= 1'b0;
        end else if (ena) begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_sh_a  <= a;
                r_sh_b  <= b;
                r_sum   <= '0;
                r_cout  <= 1'b0;
                r_carry <= 1'b0;
                r_cnt   <= '0;
                r_state <= RUN;
            end else begin
                case (r_state)
                    RUN: begin
                        // Sum bits enter at the MSB, so after WIDTH steps bit 0 is the first one.
                        r_sum   <= {w_sum_bit, r_sum[WIDTH-1:1]};
                        r_sh_a  <= r_sh_a >> 1;
                        r_sh_b  <= r_sh_b >> 1;
                        r_carry <= w_carry_next;
                        if (r_cnt == LAST) begin
                            r_cout  <= w_carry_next;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    DONE:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_ha_adder.sv
// Directed bench for serial_ha_adder: vector table plus hand-written
// sequences for back-to-back, clock-enable gating and mid-run reset.
module tb_serial_ha_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ena;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    serial_ha_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand pair, then check the busy window, the done pulse and the held result.
    task automatic run_add(input logic [W-1:0] va, input logic [W-1:0] vb,
                           input logic [W-1:0] es, input logic ec, input string tag);
        logic ok;
        a = va;
        b = vb;
        start = 1'b1;
        step();
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        check({tag, " busy_after_start"}, {busy, done, sum}, {1'b1, 1'b0, {W{1'b0}}});
        ok = 1'b1;
        for (int i = 1; i < W; i++) begin
            step();
            if (!(busy && !done)) ok = 1'b0;
        end
        check({tag, " run_window"}, ok, 1'b1);
        step();
        check({tag, " done_pulse"}, {busy, done}, 2'b01);
        check({tag, " result"}, {cout, sum}, {ec, es});
        step();
        check({tag, " after_done"}, {busy, done, cout, sum}, {1'b0, 1'b0, ec, es});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         ok;
        logic [W-1:0] snap;

        vecs[0] = '{8'h35, 8'h4A, 8'h7F, 1'b0};
        vecs[1] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
        vecs[2] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{8'h80, 8'h7F, 8'hFF, 1'b0};
        vecs[5] = '{8'hAA, 8'h55, 8'hFF, 1'b0};
        vecs[6] = '{8'h0F, 8'h01, 8'h10, 1'b0};
        vecs[7] = '{8'hC3, 8'h5A, 8'h1D, 1'b1};

        rst_n = 1'b0;
        ena   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;

        // Reset, then a long idle stretch.
        repeat (3) step();
        check("reset_outputs", {busy, done, cout, sum}, '0);
        rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if ({busy, done, cout, sum} !== '0) ok = 1'b0;
        end
        check("idle_20_cycles", ok, 1'b1);

        // Basic add with the result held through idle cycles.
        run_add(8'h35, 8'h4A, 8'h7F, 1'b0, "basic");
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if ({busy, done, cout, sum} !== {1'b0, 1'b0, 1'b0, 8'h7F}) ok = 1'b0;
        end
        check("basic_hold_10", ok, 1'b1);

        for (int v = 0; v < 8; v++)
            run_add(vecs[v].a, vecs[v].b, vecs[v].exp_sum, vecs[v].exp_cout,
                    $sformatf("vec%0d", v));

        // Back-to-back with start held high; second pair captured straight from DONE.
        a = 8'h10;
        b = 8'h20;
        start = 1'b1;
        step();
        check("b2b_first_accept", {busy, done}, 2'b10);
        a = 8'h80;
        b = 8'h80;
        ok = 1'b1;
        for (int i = 1; i < W; i++) begin
            step();
            if (!(busy && !done)) ok = 1'b0;
        end
        check("b2b_first_run", ok, 1'b1);
        step();
        check("b2b_first_done", {busy, done, cout, sum}, {1'b0, 1'b1, 1'b0, 8'h30});
        step();
        check("b2b_second_accept", {busy, done, cout, sum}, {1'b1, 1'b0, 1'b0, 8'h00});
        start = 1'b0;
        ok = 1'b1;
        for (int i = 1; i < W; i++) begin
            if (i == 3) begin
                start = 1'b1;
                a = 8'hFF;
                b = 8'hFF;
            end else begin
                start = 1'b0;
            end
            step();
            if (!(busy && !done)) ok = 1'b0;
        end
        start = 1'b0;
        check("b2b_second_run", ok, 1'b1);
        step();
        check("b2b_second_done", {busy, done, cout, sum}, {1'b0, 1'b1, 1'b1, 8'h00});
        step();
        check("b2b_back_idle", {busy, done}, 2'b00);

        // Clock-enable gap mid-RUN, then another one while done is high.
        a = 8'h12;
        b = 8'h34;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        snap = sum;
        ena = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (!(busy && !done && sum === snap)) ok = 1'b0;
        end
        check("ena_freeze_run", ok, 1'b1);
        ena = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < W - 4; i++) begin
            step();
            if (!(busy && !done)) ok = 1'b0;
        end
        check("ena_run_resumed", ok, 1'b1);
        step();
        check("ena_done", {busy, done, cout, sum}, {1'b0, 1'b1, 1'b0, 8'h46});
        ena = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (!(done && !busy && sum === 8'h46)) ok = 1'b0;
        end
        check("ena_done_stretched", ok, 1'b1);
        ena = 1'b1;
        step();
        check("ena_done_released", {busy, done, cout, sum}, {1'b0, 1'b0, 1'b0, 8'h46});

        // Asynchronous reset in the middle of RUN.
        a = 8'h5A;
        b = 8'h33;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        check("pre_reset_partial", {busy, sum}, {1'b1, 8'hD0});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_clears", {busy, done, cout, sum}, '0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("post_reset_idle", {busy, done, cout, sum}, '0);
        run_add(8'h01, 8'h01, 8'h02, 1'b0, "post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
